// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM controller: FSM encoding, sequence lengths, strobe levels.
package sram_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWr   = 2'd1,
        StRd   = 2'd2,
        StDone = 2'd3
    } state_e;

    // Halfword accesses per request type.
    localparam int unsigned RD_HALFWORDS = 4;
    localparam int unsigned WR_HALFWORDS = 2;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    // Strobe levels while the bus is idle; chip, upper and lower byte enables stay asserted.
    localparam logic SRAM_WE_N_IDLE = 1'b1;
    localparam logic SRAM_OE_N_IDLE = 1'b1;
    localparam logic SRAM_CE_N_ON   = 1'b0;
    localparam logic SRAM_BE_N_ON   = 1'b0;

endpackage

// File: rtl/sram_slot_timer.sv
// Slot timer: counts cycles within a halfword slot and halfwords within a sequence.
module sram_slot_timer
    import sram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       active_i,
    input  logic       seq_rd_i,
    output logic [1:0] hw_idx_o,
    output logic       slot_last_o,
    output logic       seq_last_o
);

    localparam logic [2:0] WaitMax = 3'(WAIT_CYCLES);

    logic [2:0] wait_q, wait_d;
    logic [1:0] hw_q, hw_d;
    logic [1:0] last_hw;

    assign last_hw     = seq_rd_i ? 2'(RD_HALFWORDS - 1) : 2'(WR_HALFWORDS - 1);
    assign slot_last_o = (wait_q == WaitMax);
    assign seq_last_o  = slot_last_o && (hw_q == last_hw);
    assign hw_idx_o    = hw_q;

    // Next-state: both counters held at zero outside a sequence, so every sequence starts clean.
    always_comb begin
        wait_d = wait_q;
        hw_d   = hw_q;
        if (!active_i) begin
            wait_d = '0;
            hw_d   = '0;
        end else if (slot_last_o) begin
            wait_d = '0;
            hw_d   = hw_q + 2'd1;
        end else begin
            wait_d = wait_q + 3'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q <= '0;
            hw_q   <= '0;
        end else begin
            wait_q <= wait_d;
            hw_q   <= hw_d;
        end
    end

endmodule

// File: rtl/sram_controller.sv
// SRAM controller: 64-bit block reads as 4 halfword accesses, 32-bit writes as 2.
// Optional macro SRAM_ACCESS_COUNT_EN adds saturating rd_count/wr_count outputs.
module sram_controller
    import sram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       address,
    input  logic [31:0]       wdata,
    output logic [63:0]       rdata,
    output logic              ready,
    inout  wire  [15:0]       SRAM_DQ,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_WE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
`ifdef SRAM_ACCESS_COUNT_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    state_e            state_q, state_d;
    logic [ADDR_W-2:0] word_q;
    logic [ADDR_W-2:0] word_off;
    logic [31:0]       wdata_q;
    logic [47:0]       rbuf_q;
    logic [63:0]       rdata_q;
    logic [1:0]        hw_idx;
    logic              slot_last, seq_last, seq_rd, active, accept;
    logic              sram_dq_oe;
    logic [15:0]       sram_dq_out;

    assign seq_rd   = (state_q == StRd);
    assign active   = (state_q == StWr) || seq_rd;
    assign accept   = (state_q == StIdle) && (wr_en || rd_en);
    // Word (halfword-pair) index of the CPU offset; wraps naturally at the SRAM size.
    assign word_off = (ADDR_W-1)'((address - BASE_ADDR) >> 2);

    sram_slot_timer #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_slot_timer (
        .clk        (clk),
        .rst        (rst),
        .active_i   (active),
        .seq_rd_i   (seq_rd),
        .hw_idx_o   (hw_idx),
        .slot_last_o(slot_last),
        .seq_last_o (seq_last)
    );

    // FSM next-state and ready; write wins when both requests are present.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready = ~(wr_en | rd_en);
                if (wr_en) begin
                    state_d = StWr;
                end else if (rd_en) begin
                    state_d = StRd;
                end
            end
            StWr:   if (seq_last) state_d = StDone;
            StRd:   if (seq_last) state_d = StDone;
            StDone: begin
                ready   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch address and write data at acceptance so the CPU side may change mid-access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            word_q  <= word_off;
            wdata_q <= wdata;
        end
    end

    // Collect read halfwords in a buffer; rdata only changes when the whole block is in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rbuf_q  <= '0;
            rdata_q <= '0;
        end else if (seq_rd && slot_last) begin
            if (seq_last) begin
                rdata_q <= {SRAM_DQ, rbuf_q};
            end else begin
                case (hw_idx)
                    2'd0:    rbuf_q[15:0]  <= SRAM_DQ;
                    2'd1:    rbuf_q[31:16] <= SRAM_DQ;
                    default: rbuf_q[47:32] <= SRAM_DQ;
                endcase
            end
        end
    end

    // Bus drive: address, strobes and write data for the current slot.
    always_comb begin
        SRAM_WE_N   = SRAM_WE_N_IDLE;
        SRAM_OE_N   = SRAM_OE_N_IDLE;
        SRAM_ADDR   = '0;
        sram_dq_oe  = 1'b0;
        sram_dq_out = wdata_q[15:0];
        if (state_q == StWr) begin
            // WE_N rises on the last cycle of the slot so data is held past the write edge.
            SRAM_WE_N   = (WAIT_CYCLES != 0) ? slot_last : 1'b0;
            SRAM_ADDR   = {word_q, hw_idx[0]};
            sram_dq_oe  = 1'b1;
            sram_dq_out = hw_idx[0] ? wdata_q[31:16] : wdata_q[15:0];
        end else if (seq_rd) begin
            SRAM_OE_N = 1'b0;
            SRAM_ADDR = {word_q[ADDR_W-2:1], hw_idx};
        end
    end

    assign SRAM_DQ   = sram_dq_oe ? sram_dq_out : 16'hzzzz;
    assign SRAM_CE_N = SRAM_CE_N_ON;
    assign SRAM_UB_N = SRAM_BE_N_ON;
    assign SRAM_LB_N = SRAM_BE_N_ON;
    assign rdata     = rdata_q;

`ifdef SRAM_ACCESS_COUNT_EN
    logic [15:0] rd_count_q, wr_count_q;

    // Saturating completion counters, bumped on the transition into DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else if (seq_last) begin
            if (seq_rd && (rd_count_q != 16'hFFFF)) rd_count_q <= rd_count_q + 16'd1;
            if (!seq_rd && (wr_count_q != 16'hFFFF)) wr_count_q <= wr_count_q + 16'd1;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: one instance with WAIT_CYCLES=1 (dut1) and one with 0 (dut0).
module tb_sram_controller;

    typedef struct packed {
        logic [17:0] addr;
        logic        we_n;
        logic        oe_n;
        logic        chk_dq;
        logic [15:0] dq;
    } cyc_t;

    logic clk, rst;
    logic wr_en1, rd_en1, ready1, we1, oe1, ce1, ub1, lb1;
    logic wr_en0, rd_en0, ready0, we0, oe0, ce0, ub0, lb0;
    logic [31:0] addr1, wdata1, addr0, wdata0;
    logic [63:0] rdata1, rdata0;
    logic [17:0] sa1, sa0;
    wire  [15:0] dq1, dq0;
`ifdef SRAM_ACCESS_COUNT_EN
    logic [15:0] rd_count1, wr_count1, rd_count0, wr_count0;
`endif

    int checks = 0;
    int errors = 0;

    cyc_t        exp_q[$];
    int          exp_len_q[$];
    int          exp_lat_q[$];
    logic [63:0] exp_rd_q[$];
    cyc_t        obs_q[$];
    int          obs_lat;
    logic [63:0] obs_rdata;

    logic [15:0] mem1 [256];
    logic [15:0] mem0 [256];
    logic [15:0] ref1 [256];
    logic [15:0] ref0 [256];
    bit          loaded = 1'b0;

    sram_controller #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1), .address(addr1), .wdata(wdata1),
        .rdata(rdata1), .ready(ready1), .SRAM_DQ(dq1), .SRAM_ADDR(sa1), .SRAM_WE_N(we1),
        .SRAM_OE_N(oe1), .SRAM_CE_N(ce1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
`ifdef SRAM_ACCESS_COUNT_EN
        , .rd_count(rd_count1), .wr_count(wr_count1)
`endif
    );

    sram_controller #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en0), .rd_en(rd_en0), .address(addr0), .wdata(wdata0),
        .rdata(rdata0), .ready(ready0), .SRAM_DQ(dq0), .SRAM_ADDR(sa0), .SRAM_WE_N(we0),
        .SRAM_OE_N(oe0), .SRAM_CE_N(ce0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
`ifdef SRAM_ACCESS_COUNT_EN
        , .rd_count(rd_count0), .wr_count(wr_count0)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] pat(input int i);
        return 16'(i * 257) ^ 16'hC3A5;
    endfunction

    // Asynchronous SRAM models (low 8 address bits decoded).
    assign dq1 = (!oe1 && we1) ? mem1[sa1[7:0]] : 16'hzzzz;
    assign dq0 = (!oe0 && we0) ? mem0[sa0[7:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= pat(i);
                mem0[i] <= pat(i);
            end
            loaded <= 1'b1;
        end else begin
            if (!we1) mem1[sa1[7:0]] <= dq1;
            if (!we0) mem0[sa0[7:0]] <= dq0;
        end
    end

    // Scoreboard push: expected bus cycles, latency and reference memory update for a write.
    task automatic push_write(input bit s0, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] off;
        logic [17:0] b;
        cyc_t e;
        int waitc;
        waitc = s0 ? 0 : 1;
        off = a - 32'd1024;
        b = {off[18:2], 1'b0};
        for (int h = 0; h < 2; h++) begin
            for (int w = 0; w <= waitc; w++) begin
                e.addr   = b + 18'(h);
                e.we_n   = (waitc != 0) && (w == waitc);
                e.oe_n   = 1'b1;
                e.chk_dq = 1'b1;
                e.dq     = (h == 1) ? wd[31:16] : wd[15:0];
                exp_q.push_back(e);
            end
            if (s0) ref0[b[7:0] + 8'(h)] = (h == 1) ? wd[31:16] : wd[15:0];
            else    ref1[b[7:0] + 8'(h)] = (h == 1) ? wd[31:16] : wd[15:0];
        end
        exp_len_q.push_back(2 * (waitc + 1));
        exp_lat_q.push_back(1 + 2 * (waitc + 1));
    endtask

    // Scoreboard push for an 8-byte-aligned block read.
    task automatic push_read(input bit s0, input logic [31:0] a);
        logic [31:0] off;
        logic [17:0] b;
        logic [63:0] blk;
        cyc_t e;
        int waitc;
        waitc = s0 ? 0 : 1;
        off = a - 32'd1024;
        b = {off[18:3], 2'b00};
        for (int h = 0; h < 4; h++) begin
            for (int w = 0; w <= waitc; w++) begin
                e.addr   = b + 18'(h);
                e.we_n   = 1'b1;
                e.oe_n   = 1'b0;
                e.chk_dq = 1'b0;
                e.dq     = '0;
                exp_q.push_back(e);
            end
            blk[16*h +: 16] = s0 ? ref0[b[7:0] + 8'(h)] : ref1[b[7:0] + 8'(h)];
        end
        exp_rd_q.push_back(blk);
        exp_len_q.push_back(4 * (waitc + 1));
        exp_lat_q.push_back(1 + 4 * (waitc + 1));
    endtask

    // Drive one request from an IDLE-cycle negedge and record the bus until ready (bounded).
    // Address/wdata are scrambled after acceptance; the DUT must have latched them.
    task automatic run_access(input bit s0, input bit wr, input bit rd, input logic [31:0] a,
                              input logic [31:0] wd, input bit keep_rd);
        cyc_t o;
        obs_q.delete();
        obs_lat = -1;
        if (s0) begin wr_en0 = wr; rd_en0 = rd; addr0 = a; wdata0 = wd; end
        else    begin wr_en1 = wr; rd_en1 = rd; addr1 = a; wdata1 = wd; end
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if ((s0 ? ready0 : ready1) === 1'b1) begin
                obs_lat   = n;
                obs_rdata = s0 ? rdata0 : rdata1;
                if (s0) begin wr_en0 = 1'b0; rd_en0 = keep_rd & rd; end
                else    begin wr_en1 = 1'b0; rd_en1 = keep_rd & rd; end
                break;
            end
            o.addr   = s0 ? sa0 : sa1;
            o.we_n   = s0 ? we0 : we1;
            o.oe_n   = s0 ? oe0 : oe1;
            o.chk_dq = 1'b0;
            o.dq     = s0 ? dq0 : dq1;
            obs_q.push_back(o);
            if (s0) begin addr0 = ~a; wdata0 = ~wd; end
            else    begin addr1 = ~a; wdata1 = ~wd; end
        end
        if (obs_lat < 0) begin
            wr_en0 = 1'b0; rd_en0 = 1'b0; wr_en1 = 1'b0; rd_en1 = 1'b0;
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({ready1, we1, oe1, ce1, ub1, lb1} !== 6'b111000) begin
            errors++;
            $display("FAIL reset_strobes1: got %b want 111000", {ready1, we1, oe1, ce1, ub1, lb1});
        end
        checks++;
        if ({ready0, we0, oe0, ce0, ub0, lb0} !== 6'b111000) begin
            errors++;
            $display("FAIL reset_strobes0: got %b want 111000", {ready0, we0, oe0, ce0, ub0, lb0});
        end
        checks++;
        if (sa1 !== 18'd0 || rdata1 !== 64'd0) begin
            errors++;
            $display("FAIL reset_addr_rdata: got addr=%h rdata=%h want 0/0", sa1, rdata1);
        end
        checks++;
        if (dut1.sram_dq_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_dq_z: dq driven=%b want 0", dut1.sram_dq_oe);
        end
    endtask

    task automatic test_write_read;
        cyc_t e, o;
        int n, el;
        logic [63:0] er;
        checks++;
        if (ready1 !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", ready1); end
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                push_write(1'b0, 32'd1028, 32'hDEADBEEF);
                run_access(1'b0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0);
            end else begin
                push_read(1'b0, 32'd1024);
                run_access(1'b0, 1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
            end
            el = exp_lat_q.pop_front();
            checks++;
            if (obs_lat != el) begin errors++; $display("FAIL wr_rd_lat%0d: got %0d want %0d", k, obs_lat, el); end
            n = exp_len_q.pop_front();
            for (int i = 0; i < n; i++) begin
                e = exp_q.pop_front();
                o = (i < obs_q.size()) ? obs_q[i] : '0;
                checks++;
                if (o.addr !== e.addr || o.we_n !== e.we_n || o.oe_n !== e.oe_n ||
                    (e.chk_dq && o.dq !== e.dq)) begin
                    errors++;
                    $display("FAIL wr_rd_cyc%0d.%0d: got a=%h we=%b oe=%b dq=%h want a=%h we=%b oe=%b dq=%h",
                             k, i, o.addr, o.we_n, o.oe_n, o.dq, e.addr, e.we_n, e.oe_n, e.dq);
                end
            end
            @(negedge clk);
        end
        er = exp_rd_q.pop_front();
        checks++;
        if (obs_rdata !== er || obs_rdata[63:32] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_rd_rdata: got %h want %h", obs_rdata, er);
        end
    endtask

    task automatic test_reset_mid_read;
        rd_en1 = 1'b1;
        addr1  = 32'd1024;
        repeat (5) @(negedge clk);
        #2;
        rst    = 1'b0;
        rd_en1 = 1'b0;
        #1;
        checks++;
        if ({ready1, oe1, we1} !== 3'b111 || rdata1 !== 64'd0 || dut1.sram_dq_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_read: got rdy/oe/we=%b rdata=%h dq_drv=%b want 111/0/0",
                     {ready1, oe1, we1}, rdata1, dut1.sram_dq_oe);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alignment;
        logic [31:0] addrs [4];
        cyc_t e, o;
        int n, el;
        logic [63:0] er;
        addrs[0] = 32'd1030; addrs[1] = 32'd1037; addrs[2] = 32'd1016; addrs[3] = 32'd3431;
        foreach (addrs[k]) begin
            push_read(1'b0, addrs[k]);
            run_access(1'b0, 1'b0, 1'b1, addrs[k], 32'h0, 1'b0);
            el = exp_lat_q.pop_front();
            checks++;
            if (obs_lat != el) begin errors++; $display("FAIL align_lat%0d: got %0d want %0d", k, obs_lat, el); end
            n = exp_len_q.pop_front();
            for (int i = 0; i < n; i++) begin
                e = exp_q.pop_front();
                o = (i < obs_q.size()) ? obs_q[i] : '0;
                checks++;
                if (o.addr !== e.addr || o.we_n !== e.we_n || o.oe_n !== e.oe_n) begin
                    errors++;
                    $display("FAIL align_cyc%0d.%0d: got a=%h we=%b oe=%b want a=%h we=%b oe=%b",
                             k, i, o.addr, o.we_n, o.oe_n, e.addr, e.we_n, e.oe_n);
                end
            end
            er = exp_rd_q.pop_front();
            checks++;
            if (obs_rdata !== er) begin errors++; $display("FAIL align_rdata%0d: got %h want %h", k, obs_rdata, er); end
            @(negedge clk);
        end
    endtask

    task automatic test_priority;
        cyc_t e, o;
        int n, el;
        logic [63:0] er;
        push_write(1'b0, 32'd1040, 32'h12345678);
        push_read(1'b0, 32'd1040);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) run_access(1'b0, 1'b1, 1'b1, 32'd1040, 32'h12345678, 1'b1);
            else        run_access(1'b0, 1'b0, 1'b1, 32'd1040, 32'h0, 1'b0);
            el = exp_lat_q.pop_front();
            checks++;
            if (obs_lat != el) begin errors++; $display("FAIL prio_lat%0d: got %0d want %0d", k, obs_lat, el); end
            n = exp_len_q.pop_front();
            for (int i = 0; i < n; i++) begin
                e = exp_q.pop_front();
                o = (i < obs_q.size()) ? obs_q[i] : '0;
                checks++;
                if (o.addr !== e.addr || o.we_n !== e.we_n || o.oe_n !== e.oe_n ||
                    (e.chk_dq && o.dq !== e.dq)) begin
                    errors++;
                    $display("FAIL prio_cyc%0d.%0d: got a=%h we=%b oe=%b dq=%h want a=%h we=%b oe=%b dq=%h",
                             k, i, o.addr, o.we_n, o.oe_n, o.dq, e.addr, e.we_n, e.oe_n, e.dq);
                end
            end
            @(negedge clk);
        end
        er = exp_rd_q.pop_front();
        checks++;
        if (obs_rdata !== er) begin errors++; $display("FAIL prio_rdata: got %h want %h", obs_rdata, er); end
    endtask

    task automatic test_wait0;
        cyc_t e, o;
        int n, el;
        logic [63:0] er;
        for (int k = 0; k < 3; k++) begin
            if (k == 0) begin
                push_write(1'b1, 32'd1028, 32'hCAFEF00D);
                run_access(1'b1, 1'b1, 1'b0, 32'd1028, 32'hCAFEF00D, 1'b0);
            end else begin
                push_read(1'b1, 32'd1024 + 32'(k - 1) * 32'd8);
                run_access(1'b1, 1'b0, 1'b1, 32'd1024 + 32'(k - 1) * 32'd8, 32'h0, 1'b0);
            end
            el = exp_lat_q.pop_front();
            checks++;
            if (obs_lat != el) begin errors++; $display("FAIL w0_lat%0d: got %0d want %0d", k, obs_lat, el); end
            n = exp_len_q.pop_front();
            for (int i = 0; i < n; i++) begin
                e = exp_q.pop_front();
                o = (i < obs_q.size()) ? obs_q[i] : '0;
                checks++;
                if (o.addr !== e.addr || o.we_n !== e.we_n || o.oe_n !== e.oe_n ||
                    (e.chk_dq && o.dq !== e.dq)) begin
                    errors++;
                    $display("FAIL w0_cyc%0d.%0d: got a=%h we=%b oe=%b dq=%h want a=%h we=%b oe=%b dq=%h",
                             k, i, o.addr, o.we_n, o.oe_n, o.dq, e.addr, e.we_n, e.oe_n, e.dq);
                end
            end
            if (k != 0) begin
                er = exp_rd_q.pop_front();
                checks++;
                if (obs_rdata !== er) begin errors++; $display("FAIL w0_rdata%0d: got %h want %h", k, obs_rdata, er); end
            end
            @(negedge clk);
        end
    endtask

`ifdef SRAM_ACCESS_COUNT_EN
    task automatic test_counters;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (rd_count1 !== 16'd0 || wr_count1 !== 16'd0) begin
            errors++;
            $display("FAIL cnt_reset: got rd=%0d wr=%0d want 0/0", rd_count1, wr_count1);
        end
        for (int k = 0; k < 5; k++) begin
            if (k < 3) run_access(1'b0, 1'b0, 1'b1, 32'd1024 + 32'(k) * 32'd8, 32'h0, 1'b0);
            else       run_access(1'b0, 1'b1, 1'b0, 32'd1024 + 32'(k) * 32'd4, 32'h1111 * 32'(k), 1'b0);
            @(negedge clk);
        end
        checks++;
        if (rd_count1 !== 16'd3 || wr_count1 !== 16'd2) begin
            errors++;
            $display("FAIL cnt_value: got rd=%0d wr=%0d want 3/2", rd_count1, wr_count1);
        end
        force dut1.wr_count_q = 16'hFFFF;
        @(negedge clk);
        release dut1.wr_count_q;
        run_access(1'b0, 1'b1, 1'b0, 32'd1100, 32'h55AA55AA, 1'b0);
        @(negedge clk);
        checks++;
        if (wr_count1 !== 16'hFFFF || rd_count1 !== 16'd3) begin
            errors++;
            $display("FAIL cnt_saturate: got rd=%0d wr=%h want 3/ffff", rd_count1, wr_count1);
        end
    endtask
`endif

    initial begin
        rst = 1'b0;
        wr_en1 = 1'b0; rd_en1 = 1'b0; addr1 = '0; wdata1 = '0;
        wr_en0 = 1'b0; rd_en0 = 1'b0; addr0 = '0; wdata0 = '0;
        for (int i = 0; i < 256; i++) begin
            ref1[i] = pat(i);
            ref0[i] = pat(i);
        end
        #3;
        test_reset;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_write_read;
        test_reset_mid_read;
        test_alignment;
        test_priority;
        test_wait0;
`ifdef SRAM_ACCESS_COUNT_EN
        test_counters;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
